// File: rtl/mul_div_unit_pkg.sv
// Shared multiply/divide definitions: op codes, default latencies and result type.
// The decoder imports the same op codes, so both sides agree on md_op values.
package md_pkg;

  typedef enum logic [3:0] {
    MD_NOP   = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MADD  = 4'd7,
    MD_MADDU = 4'd8
  } md_op_e;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } md_result_t;

endpackage

// File: rtl/mul_div_unit_if.sv
// EX-stage request/result bundle between the pipeline and the multiply/divide unit.
interface mul_div_unit_if;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, md_op, operand1, operand2, input busy, hi, lo);
  modport slave  (input start, md_op, operand1, operand2, output busy, hi, lo);
endinterface

// File: rtl/mul_div_unit_calc.sv
// Combinational multiply/divide datapath producing the {hi,lo} result for one op.
// MADD/MADDU products are produced only when MDU_MADD_EN is defined.
module md_calc
  import md_pkg::*;
(
  input  logic [3:0]  md_op,
  input  logic [31:0] operand1,
  input  logic [31:0] operand2,
  output md_result_t  result,
  output logic        div_by_zero
);

  logic        is_signed;
  logic [63:0] ext_a, ext_b, product;
  logic        a_neg, b_neg;
  logic [31:0] abs_a, abs_b, uq, ur, quot, rem;

  assign is_signed = (md_op == MD_MULT) || (md_op == MD_DIV) || (md_op == MD_MADD);

  assign ext_a   = is_signed ? {{32{operand1[31]}}, operand1} : {32'b0, operand1};
  assign ext_b   = is_signed ? {{32{operand2[31]}}, operand2} : {32'b0, operand2};
  assign product = ext_a * ext_b;

  // Sign-magnitude division; 0x80000000 / -1 falls out as quotient 0x80000000, remainder 0.
  assign a_neg = is_signed && operand1[31];
  assign b_neg = is_signed && operand2[31];
  assign abs_a = a_neg ? -operand1 : operand1;
  assign abs_b = b_neg ? -operand2 : operand2;
  assign uq    = abs_a / abs_b;
  assign ur    = abs_a % abs_b;
  assign quot  = (a_neg ^ b_neg) ? -uq : uq;
  assign rem   = a_neg ? -ur : ur;

  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    result      = '0;
    div_by_zero = 1'b0;
    case (md_op)
      MD_MULT, MD_MULTU: result = product;
      MD_DIV, MD_DIVU: begin
        result      = {rem, quot};
        div_by_zero = (operand2 == 32'd0);
      end
`ifdef MDU_MADD_EN
      MD_MADD, MD_MADDU: result = product;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Define MDU_MADD_EN to enable MADD/MADDU accumulate into {hi,lo}.
module mul_div_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input logic          clk,
  input logic          reset,
  mul_div_unit_if.slave bus
);

  logic [3:0] counter;
  md_result_t hilo, pending, calc_result, commit_value;
  logic       pending_skip;
  logic       calc_div0;
`ifdef MDU_MADD_EN
  logic       pending_acc;
`endif

  md_calc u_calc (
    .md_op       (bus.md_op),
    .operand1    (bus.operand1),
    .operand2    (bus.operand2),
    .result      (calc_result),
    .div_by_zero (calc_div0)
  );

  assign bus.busy = (counter != 4'd0);
  assign bus.hi   = hilo.hi;
  assign bus.lo   = hilo.lo;

  // Accumulate uses the {hi,lo} present at completion, not at issue.
`ifdef MDU_MADD_EN
  assign commit_value = pending_acc ? md_result_t'(hilo + pending) : pending;
`else
  assign commit_value = pending;
`endif

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) begin
      // NOTE: pending is cleared as well so an aborted op leaves nothing to commit.
      hilo         <= '0;
      pending      <= '0;
      pending_skip <= 1'b0;
      counter      <= 4'd0;
`ifdef MDU_MADD_EN
      pending_acc  <= 1'b0;
`endif
    end else if (counter != 4'd0) begin
      counter <= counter - 4'd1;
      if (counter == 4'd1 && !pending_skip) hilo <= commit_value;
    end else if (bus.start) begin
      case (bus.md_op)
        MD_MTHI: hilo.hi <= bus.operand1;
        MD_MTLO: hilo.lo <= bus.operand1;
        MD_MULT, MD_MULTU: begin
          pending      <= calc_result;
          pending_skip <= 1'b0;
          counter      <= 4'(MULT_CYCLES);
`ifdef MDU_MADD_EN
          pending_acc  <= 1'b0;
`endif
        end
        MD_DIV, MD_DIVU: begin
          pending      <= calc_result;
          pending_skip <= calc_div0;
          counter      <= 4'(DIV_CYCLES);
`ifdef MDU_MADD_EN
          pending_acc  <= 1'b0;
`endif
        end
`ifdef MDU_MADD_EN
        MD_MADD, MD_MADDU: begin
          pending      <= calc_result;
          pending_skip <= 1'b0;
          counter      <= 4'(MULT_CYCLES);
          pending_acc  <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
